apb_master: RTL and testbench
=============================

# apb_master

Single-clock APB register-bank peripheral that responds to APB transfers. It decodes an 8-bit address onto a small bank of 8-bit registers, inserts a configurable number of wait states, and returns read data with PREADY. It sits behind the system APB bridge as a simple control/status register block.

## Interface
- DATA_WIDTH, 8, width of PWDATA/PRDATA and each register
- ADDR_WIDTH, 8, width of PADDR
- NUM_REGS, 4, number of registers; valid addresses 0..NUM_REGS-1
- WAIT_STATES, 0, PREADY-low cycles inserted in each access phase (0..15)

- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  reset; synchronous, active-high (asserted when 1), sampled on PCLK rising edge
- PSEL  in  1  peripheral select
- PENABLE  in  1  access-phase strobe
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  register address (byte index, no alignment)
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  out  DATA_WIDTH  read data, registered
- PREADY  out  1  transfer-complete strobe, registered

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: PSEL=1 and PENABLE=0 sampled -> SETUP; capture PADDR, PWRITE, PWDATA; load wait counter with WAIT_STATES. PENABLE=1 without prior setup is ignored (stay IDLE).
- SETUP -> ACCESS unconditionally. In this edge: if counter==0 set PREADY=1, else PREADY=0 and decrement. For reads, PRDATA <= reg[captured addr] (0 if addr >= NUM_REGS).
- ACCESS, PSEL=1 and PENABLE=1:
  - PREADY=0: decrement counter; when it reaches 0, set PREADY=1 next cycle.
  - PREADY=1: transfer completes on this edge. Write commits reg[addr] <= captured PWDATA (ignored if addr >= NUM_REGS). PREADY cleared. Next state SETUP if PSEL=1 and PENABLE=0 is also sampled in this edge (back-to-back), else IDLE.
- ACCESS with PSEL=0: transfer aborted, no write, PREADY cleared, -> IDLE.
- PRDATA holds its value after a read until the next read loads it; writes do not change PRDATA.
- Registers are readable and writable at all valid addresses; no side effects on read.

## Timing
- Reset: all registers 0, PRDATA=0, PREADY=0, state IDLE, counter 0. Reset has priority over any transfer in progress; an in-flight write does not commit.
- Minimum transfer (WAIT_STATES=0): 2 cycles. Edge 1 samples setup. PREADY=1 and PRDATA are valid during cycle 2. Edge 2 completes the transfer.
- With N wait states, PREADY rises after N access cycles; the transfer takes 2+N cycles.
- PREADY is high for exactly one cycle per completed transfer.
- PADDR/PWDATA changes during ACCESS have no effect; values captured in SETUP are used.
- Write then read of the same address back-to-back returns the new data, because the write commits before the read's setup edge.

## Test plan
- Reset: assert PRESETn=1 for 2 cycles -> PRDATA=00, PREADY=0; reading addresses 0-3 returns 00.
- Writes then reads, WAIT_STATES=0: write AA/BB/CC/DD to addresses 0/1/2/3, then read 0..3 -> AA, BB, CC, DD. Each transfer has PREADY high for 1 cycle, 2 cycles per transfer.
- Wait states, WAIT_STATES=3: write 5A to address 2 -> PREADY low 3 access cycles, then high 1 cycle. Subsequent read of address 2 -> 5A after 5 cycles.
- Out-of-range address: write 77 to address 4 and to address FF -> registers 0-3 unchanged. Read of address 4 -> 00 with normal PREADY.
- Abort and reset: drop PSEL during the access phase of a write of 11 to address 1 -> reg1 unchanged. Assert reset mid-write -> all regs 00, PREADY=0.
- Back-to-back: write 3C to address 3 immediately followed by a read of address 3 -> 3C, no idle cycle required.

Source files
------------

// File: rtl/apb_master.sv
// APB control/status register bank: decodes PADDR onto NUM_REGS registers,
// inserts WAIT_STATES PREADY-low cycles per access and returns registered PRDATA.
module apb_master #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REGS    = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  // Handshake: a transfer starts on the edge that samples PSEL=1/PENABLE=0 and
  // completes on the first edge that samples PSEL=1, PENABLE=1 and PREADY=1;
  // PSEL=0 during the access phase aborts it without any register side effect.
  // SETUP is the first access-phase cycle after the setup edge; ACCESS covers
  // any further wait cycles. Both behave identically towards the bus.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    ready_d;
  logic [DATA_WIDTH-1:0]   prdata_d;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]   rd_val;
  logic                    setup_seen;
  logic                    in_xfer;
  logic                    xfer_done;
  logic                    xfer_abort;
  logic                    wr_en;

  assign setup_seen = (state_q == IDLE) && PSEL && !PENABLE;
  assign in_xfer    = (state_q != IDLE);
  assign xfer_done  = in_xfer && PSEL && PENABLE && PREADY;
  assign xfer_abort = in_xfer && !PSEL;

  always_comb begin
    rd_val = '0;
    if (PADDR < NUM_REGS_A) rd_val = regs[PADDR[IDX_W-1:0]];
  end

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (setup_seen) state_d = SETUP;
      end
      SETUP, ACCESS: begin
        if (xfer_abort || xfer_done) state_d = IDLE;
        else if (PENABLE)            state_d = ACCESS;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ready_d  = PREADY;
    cnt_d    = cnt_q;
    prdata_d = PRDATA;
    wr_en    = 1'b0;
    if (setup_seen) begin
      ready_d = (WAIT_STATES == 0);
      cnt_d   = WAIT_INIT;
      if (!PWRITE) prdata_d = rd_val;
    end else if (in_xfer) begin
      if (xfer_abort) begin
        ready_d = 1'b0;
      end else if (xfer_done) begin
        ready_d = 1'b0;
        wr_en   = wr_q && (addr_q < NUM_REGS_A);
      end else if (PENABLE && !PREADY) begin
        if (cnt_q == 4'd0) ready_d = 1'b1;
        else               cnt_d   = cnt_q - 4'd1;
      end
    end
  end

  // Datapath registers; reset wins over an in-flight write
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      cnt_q   <= '0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      PREADY <= ready_d;
      PRDATA <= prdata_d;
      if (setup_seen) begin
        wr_q    <= PWRITE;
        addr_q  <= PADDR;
        wdata_q <= PWDATA;
      end
      if (wr_en) regs[addr_q[IDX_W-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: one instance with no wait states, one with
// three, sharing the bus except for their PSEL lines.
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       rst;
  logic       psel0, psel1, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata0, prdata1;
  logic       pready0, pready1;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 PCLK = ~PCLK;

  apb_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(4), .WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0)
  );

  apb_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(4), .WAIT_STATES(3)) dut1 (
    .PCLK(PCLK), .PRESETn(rst), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? pready1 : pready0;
  endfunction

  function automatic logic [7:0] rdat(input int sel);
    return (sel == 1) ? prdata1 : prdata0;
  endfunction

  // One complete transfer; leaves PSEL high so a following call is back-to-back.
  // Reads pop their expected data from exp_q.
  task automatic xfer(input int sel, input logic wr, input logic [7:0] addr,
                      input logic [7:0] wdata, input int nwait, input string tag);
    int waits;
    logic [7:0] exp;
    @(negedge PCLK);
    check({tag, "_rdy_before"}, 32'(rdy(sel)), 32'd0);
    psel0 = (sel == 0); psel1 = (sel == 1);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge PCLK);
    penable = 1'b1;
    // bus values moving during access must not matter
    paddr = ~addr; pwdata = ~wdata;
    waits = 0;
    while (!rdy(sel) && waits < 20) begin
      @(negedge PCLK);
      waits++;
    end
    check({tag, "_waits"}, 32'(waits), 32'(nwait));
    if (!wr) begin
      if (exp_q.size() == 0) begin
        check({tag, "_expq_empty"}, 32'd1, 32'd0);
      end else begin
        exp = exp_q.pop_front();
        check({tag, "_rdata"}, 32'(rdat(sel)), 32'(exp));
      end
    end
  endtask

  task automatic go_idle();
    @(negedge PCLK);
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
  endtask

  task automatic read_all(input int sel, input int nwait, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                          input string tag);
    exp_q.push_back(d0); exp_q.push_back(d1); exp_q.push_back(d2); exp_q.push_back(d3);
    for (int i = 0; i < 4; i++) xfer(sel, 1'b0, 8'(i), 8'h00, nwait, $sformatf("%s_r%0d", tag, i));
    go_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    rst = 1'b0;
    check("rst_prdata0", 32'(prdata0), 32'h00);
    check("rst_pready0", 32'(pready0), 32'd0);
    check("rst_prdata1", 32'(prdata1), 32'h00);
    check("rst_pready1", 32'(pready1), 32'd0);
    read_all(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, "rst_rd");

    // back-to-back writes then reads, no wait states
    xfer(0, 1'b1, 8'h00, 8'hAA, 0, "w0");
    xfer(0, 1'b1, 8'h01, 8'hBB, 0, "w1");
    xfer(0, 1'b1, 8'h02, 8'hCC, 0, "w2");
    xfer(0, 1'b1, 8'h03, 8'hDD, 0, "w3");
    go_idle();
    read_all(0, 0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, "wr_rd");

    // three wait states
    xfer(1, 1'b1, 8'h02, 8'h5A, 3, "ws_w2");
    exp_q.push_back(8'h5A);
    xfer(1, 1'b0, 8'h02, 8'h00, 3, "ws_r2");
    go_idle();

    // out-of-range writes; PRDATA must keep the last read value (DD)
    xfer(0, 1'b1, 8'h04, 8'h77, 0, "oor_w4");
    xfer(0, 1'b1, 8'hFF, 8'h77, 0, "oor_wff");
    go_idle();
    check("hold_prdata", 32'(prdata0), 32'hDD);
    read_all(0, 0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, "oor_rd");
    exp_q.push_back(8'h00);
    xfer(0, 1'b0, 8'h04, 8'h00, 0, "oor_r4");
    go_idle();

    // abort: PSEL dropped in the access cycle of a write of 11 to reg1
    @(negedge PCLK);
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h11;
    @(negedge PCLK);
    psel0 = 1'b0; penable = 1'b1;
    @(negedge PCLK);
    check("abort_pready", 32'(pready0), 32'd0);
    penable = 1'b0;
    exp_q.push_back(8'hBB);
    xfer(0, 1'b0, 8'h01, 8'h00, 0, "abort_r1");
    go_idle();

    // write then immediate read of the same address
    xfer(0, 1'b1, 8'h03, 8'h3C, 0, "b2b_w3");
    exp_q.push_back(8'h3C);
    xfer(0, 1'b0, 8'h03, 8'h00, 0, "b2b_r3");
    go_idle();

    // reset in the middle of a wait-stated write
    @(negedge PCLK);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h99;
    @(negedge PCLK);
    penable = 1'b1;
    @(negedge PCLK);
    rst = 1'b1;
    @(negedge PCLK);
    check("midrst_pready1", 32'(pready1), 32'd0);
    check("midrst_prdata1", 32'(prdata1), 32'h00);
    check("midrst_prdata0", 32'(prdata0), 32'h00);
    rst = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    exp_q.push_back(8'h00);
    xfer(1, 1'b0, 8'h02, 8'h00, 3, "midrst_r2");
    go_idle();
    read_all(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, "midrst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
